alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; the port list SHALL begin with clk and rst_n.
REQ-002 The block SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted
- req_op_i  in  cs_alu_op  operation
- req_cmp_flip_i  in  1  invert compare result
- req_a_i  in  32  operand A
- req_b_i  in  32  operand B
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_result_o  out  32  result
- alu_first_cycle_o  out  1  first_cycle to the 16-bit ALU
- alu_op_o  out  cs_alu_op  op to the ALU
- alu_cmp_flip_o  out  1  cmp_flip to the ALU
- alu_a_o  out  16  ALU operand A
- alu_b_o  out  16  ALU operand B
- alu_result_i  in  16  ALU result
- alu_cmp_result_i  in  1  ALU compare bit
- alu_cmp_result_valid_i  in  1  ALU compare decided

Function
REQ-003 The FSM SHALL have the states IDLE, C1, C2 and RESP, with transitions IDLE->C1 on req_valid_i&&req_ready_o, C1->C2, C2->RESP, and RESP->IDLE on rsp_ready_i.
REQ-004 req_ready_o SHALL be 1 only in IDLE; op, flip, A and B SHALL be captured on acceptance.
REQ-005 rsp_valid_o SHALL be 1 only in RESP; rsp_result_o SHALL be held stable until rsp_ready_i is sampled high.
REQ-006 Latency from acceptance to rsp_valid_o SHALL be 3 cycles (2 cycles in the EQ early-exit case).
REQ-007 alu_op_o and alu_cmp_flip_o SHALL equal the captured values in C1 and C2; alu_first_cycle_o SHALL be 1 in C1 and 0 in C2, except as stated in REQ-010.
REQ-008 Half order SHALL be low-first (C1 = [15:0], C2 = [31:16]) for ADD, SUB, PLUS_4, AND, OR, XOR, EQ, LT, LTU and SLL, and high-first for SRL and SRA.
REQ-009 alu_b_o for shifts SHALL be {11'b0, B[4:0]} in both cycles; for all other ops it SHALL be the matching half of B.
REQ-010 Shifts with B[4]=1 SHALL follow this schedule:
- C1: fill half, first_cycle=1, b={11'b0,1'b1,B[3:0]}.
- C2: first_cycle=1, b={12'b0,B[3:0]}; alu_a_o SHALL be A[31:16] for SRL/SRA and A[15:0] for SLL.
- Results SHALL be placed as: SRL hi=C1, lo=C2; SRA hi=C1, lo=C2; SLL lo=C1, hi=C2.
REQ-011 For non-compare ops, each alu_result_i SHALL be registered into its destination half at the end of the cycle in which it is valid.
REQ-012 For EQ, LT and LTU, rsp_result_o SHALL be {31'b0, alu_cmp_result_i} sampled in the final ALU cycle.
REQ-013 All alu_* outputs SHALL be 0 in IDLE and RESP.

Reset
REQ-014 Asserting rst_n SHALL force IDLE with req_ready_o=1, rsp_valid_o=0, rsp_result_o=0 and all captured registers cleared.
REQ-015 A reset mid-operation SHALL discard the transaction without emitting a response.

Configuration
REQ-016 When ALU_SEQ_EQ_EARLY_EXIT_EN is defined, an EQ SHALL go C1->RESP if alu_cmp_result_valid_i=1 in C1, with rsp_result_o={31'b0, alu_cmp_result_i}.
REQ-017 When ALU_SEQ_EQ_EARLY_EXIT_EN is not defined, EQ SHALL always take C2, and alu_cmp_result_valid_i SHALL be ignored.

Structure
REQ-018 The shared typedefs package SHALL hold alu_seq_state_e (IDLE, C1, C2, RESP) and ALU_HALF_W=16; cs_alu_op SHALL be reused from that package.
REQ-019 Half and shift-amount operand selection SHALL be placed in the sub-module alu_seq_half_sel; result assembly and the FSM SHALL remain in alu_seq_ctrl.

Verification
REQ-020 The bench SHALL cover at least the following scenarios:
- ADD 0x0000FFFF+0x00000001 -> C1 a=FFFF b=0001 fc=1, C2 a=0000 fc=0; result 0x00010000 three cycles after acceptance.
- SRL 0x80000000 by 4 -> C1 a=8000, C2 a=0000; result 0x08000000.
- SRA 0x80000000 by 20 -> C1 b=0x14 gives FFFF; C2 fc=1, b=0x04, a=8000 gives F800; result 0xFFFFF800.
- EQ 0x00000001 vs 0x00000000 with the macro defined -> rsp_valid two cycles after acceptance, result 0; without the macro -> three cycles.
- Backpressure: rsp_ready_i=0 for 5 cycles -> result stable and req_ready_o=0 throughout; a new request is accepted the cycle after IDLE.
- rst_n asserted in C2 -> next cycle IDLE, rsp_valid_o=0 and no response emitted.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types for the 32-bit sequencer built on a 16-bit ALU: op codes, FSM states, widths.
// No logic, so no latency.
// No flow control; types and op-class helpers only.
package alu_seq_ctrl_pkg;

  localparam int ALU_HALF_W = 16;
  localparam int ALU_DATA_W = 2 * ALU_HALF_W;

  // ALU_ADD is encoding 0 so that an idle op bus reads as all-zero.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_PLUS_4 = 4'd2,
    ALU_AND    = 4'd3,
    ALU_OR     = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_EQ     = 4'd6,
    ALU_LT     = 4'd7,
    ALU_LTU    = 4'd8,
    ALU_SLL    = 4'd9,
    ALU_SRL    = 4'd10,
    ALU_SRA    = 4'd11
  } cs_alu_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C1   = 2'd1,
    C2   = 2'd2,
    RESP = 2'd3
  } alu_seq_state_e;

  function automatic logic op_is_shift(input cs_alu_op op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

  function automatic logic op_is_cmp(input cs_alu_op op);
    return op inside {ALU_EQ, ALU_LT, ALU_LTU};
  endfunction

  // Right shifts produce the upper half first, so bits shifted out of it can flow into the lower half.
  function automatic logic op_hi_first(input cs_alu_op op);
    return op inside {ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/alu_seq_half_sel.sv
// Picks which 16-bit half of A/B (or the shift amount) goes to the ALU in each sequencer cycle.
// Purely combinational, zero latency.
// No flow control; drives zeros outside the two ALU cycles.
module alu_seq_half_sel
  import alu_seq_ctrl_pkg::*;
(
  input  alu_seq_state_e        state_i,
  input  cs_alu_op              op_i,
  input  logic [ALU_DATA_W-1:0] a_i,
  input  logic [ALU_DATA_W-1:0] b_i,
  output logic                  first_cycle_o,
  output logic [ALU_HALF_W-1:0] a_o,
  output logic [ALU_HALF_W-1:0] b_o
);

  logic [ALU_HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [ALU_HALF_W-1:0] shamt, shamt_lo4;
  logic                  shift, hi_first, big_shift;

  assign a_lo      = a_i[ALU_HALF_W-1:0];
  assign a_hi      = a_i[ALU_DATA_W-1:ALU_HALF_W];
  assign b_lo      = b_i[ALU_HALF_W-1:0];
  assign b_hi      = b_i[ALU_DATA_W-1:ALU_HALF_W];
  assign shamt     = {{(ALU_HALF_W-5){1'b0}}, b_i[4:0]};
  assign shamt_lo4 = {{(ALU_HALF_W-4){1'b0}}, b_i[3:0]};
  assign shift     = op_is_shift(op_i);
  assign hi_first  = op_hi_first(op_i);
  assign big_shift = shift && b_i[4];

  // Operand routing per cycle. A shift by 16 or more becomes two independent shifts:
  // C1 shifts by the full amount (producing the sign/zero fill half), C2 restarts the ALU
  // and shifts the crossing half by amount-16 into the other result half.
  always_comb begin
    first_cycle_o = 1'b0;
    a_o           = '0;
    b_o           = '0;
    case (state_i)
      C1: begin
        first_cycle_o = 1'b1;
        a_o           = hi_first ? a_hi : a_lo;
        // For a big shift {0,1,B[3:0]} equals B[4:0], so one path covers both cases.
        b_o           = shift ? shamt : b_lo;
      end
      C2: begin
        first_cycle_o = big_shift;
        if (big_shift) begin
          a_o = (op_i == ALU_SLL) ? a_lo : a_hi;
          b_o = shamt_lo4;
        end else begin
          a_o = hi_first ? a_lo : a_hi;
          b_o = shift ? shamt : b_hi;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Runs one 32-bit ALU op as two cycles on an external 16-bit ALU and assembles the result.
// Latency 3 cycles from acceptance to rsp_valid_o (2 for an EQ early exit under ALU_SEQ_EQ_EARLY_EXIT_EN).
// One op in flight: req_ready_o only in IDLE; the response is held until rsp_ready_i is seen high.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  cs_alu_op              req_op_i,
  input  logic                  req_cmp_flip_i,
  input  logic [ALU_DATA_W-1:0] req_a_i,
  input  logic [ALU_DATA_W-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [ALU_DATA_W-1:0] rsp_result_o,
  output logic                  alu_first_cycle_o,
  output cs_alu_op              alu_op_o,
  output logic                  alu_cmp_flip_o,
  output logic [ALU_HALF_W-1:0] alu_a_o,
  output logic [ALU_HALF_W-1:0] alu_b_o,
  input  logic [ALU_HALF_W-1:0] alu_result_i,
  input  logic                  alu_cmp_result_i,
  input  logic                  alu_cmp_result_valid_i
);

  alu_seq_state_e        state_q, state_d;
  cs_alu_op              op_q, op_d;
  logic                  flip_q, flip_d;
  logic [ALU_DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  alu_active, hi_first, cmp_op, eq_early;
  logic [ALU_DATA_W-1:0] cmp_word;

  assign hi_first = op_hi_first(op_q);
  assign cmp_op   = op_is_cmp(op_q);
  assign cmp_word = {{(ALU_DATA_W-1){1'b0}}, alu_cmp_result_i};

`ifdef ALU_SEQ_EQ_EARLY_EXIT_EN
  assign eq_early = (op_q == ALU_EQ) && alu_cmp_result_valid_i;
`else
  logic unused_cmp_valid;
  assign unused_cmp_valid = alu_cmp_result_valid_i;
  assign eq_early         = 1'b0;
`endif

  // State, captured request and result registers; reset discards any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= ALU_ADD;
      flip_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flip_q  <= flip_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Next state, request capture and result assembly; each ALU half lands in its destination
  // half at the end of the cycle that produced it.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    flip_d  = flip_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          flip_d  = req_cmp_flip_i;
          a_d     = req_a_i;
          b_d     = req_b_i;
          state_d = C1;
        end
      end
      C1: begin
        state_d = C2;
        if (cmp_op) begin
          if (eq_early) begin
            res_d   = cmp_word;
            state_d = RESP;
          end
        end else if (hi_first) begin
          res_d[ALU_DATA_W-1:ALU_HALF_W] = alu_result_i;
        end else begin
          res_d[ALU_HALF_W-1:0] = alu_result_i;
        end
      end
      C2: begin
        state_d = RESP;
        if (cmp_op) begin
          res_d = cmp_word;
        end else if (hi_first) begin
          res_d[ALU_HALF_W-1:0] = alu_result_i;
        end else begin
          res_d[ALU_DATA_W-1:ALU_HALF_W] = alu_result_i;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_result_o   = res_q;
  assign alu_active     = (state_q == C1) || (state_q == C2);
  assign alu_op_o       = alu_active ? op_q : ALU_ADD;
  assign alu_cmp_flip_o = alu_active & flip_q;

  alu_seq_half_sel u_half_sel (
    .state_i       (state_q),
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .first_cycle_o (alu_first_cycle_o),
    .a_o           (alu_a_o),
    .b_o           (alu_b_o)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: plays the external 16-bit ALU and scoreboards 32-bit results.
// Expected results come from plain 32-bit arithmetic; latency from acceptance is checked too.
// Response backpressure is driven per transaction (random hold, plus a directed 5-cycle hold).
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i, req_ready_o, req_cmp_flip_i;
  cs_alu_op    req_op_i;
  logic [31:0] req_a_i, req_b_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic        alu_first_cycle_o, alu_cmp_flip_o;
  cs_alu_op    alu_op_o;
  logic [15:0] alu_a_o, alu_b_o, alu_result_i;
  logic        alu_cmp_result_i, alu_cmp_result_valid_i;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          issued = 0;
  int          resp_seen = 0;
  bit          in_rsp = 0;

  logic [31:0] exp_res_q[$];
  int unsigned exp_lat_q[$];
  int unsigned exp_acc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq_ctrl dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .req_op_i               (req_op_i),
    .req_cmp_flip_i         (req_cmp_flip_i),
    .req_a_i                (req_a_i),
    .req_b_i                (req_b_i),
    .rsp_valid_o            (rsp_valid_o),
    .rsp_ready_i            (rsp_ready_i),
    .rsp_result_o           (rsp_result_o),
    .alu_first_cycle_o      (alu_first_cycle_o),
    .alu_op_o               (alu_op_o),
    .alu_cmp_flip_o         (alu_cmp_flip_o),
    .alu_a_o                (alu_a_o),
    .alu_b_o                (alu_b_o),
    .alu_result_i           (alu_result_i),
    .alu_cmp_result_i       (alu_cmp_result_i),
    .alu_cmp_result_valid_i (alu_cmp_result_valid_i)
  );

  // ---------------- external 16-bit ALU model ----------------
  // first_cycle=1 starts a fresh op; first_cycle=0 continues from the saved carry/compare/spill state.
  logic        carry_q, eq_q, lt_q, eq_now, lt_now, hi_lt;
  logic [15:0] spill_q, spill_d;
  logic [16:0] sum;
  logic [31:0] sh;

  always_comb begin
    sum = '0; sh = '0; spill_d = '0; eq_now = 1'b0; lt_now = 1'b0; hi_lt = 1'b0;
    alu_result_i = '0; alu_cmp_result_i = 1'b0; alu_cmp_result_valid_i = 1'b0;
    case (alu_op_o)
      ALU_ADD: begin
        sum = {1'b0, alu_a_o} + {1'b0, alu_b_o} + {16'b0, ~alu_first_cycle_o & carry_q};
        alu_result_i = sum[15:0];
      end
      ALU_SUB: begin
        sum = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + {16'b0, alu_first_cycle_o | carry_q};
        alu_result_i = sum[15:0];
      end
      ALU_PLUS_4: begin
        sum = {1'b0, alu_a_o} + (alu_first_cycle_o ? 17'd4 : {16'b0, carry_q});
        alu_result_i = sum[15:0];
      end
      ALU_AND: alu_result_i = alu_a_o & alu_b_o;
      ALU_OR:  alu_result_i = alu_a_o | alu_b_o;
      ALU_XOR: alu_result_i = alu_a_o ^ alu_b_o;
      ALU_EQ: begin
        eq_now = (alu_a_o == alu_b_o) && (alu_first_cycle_o || eq_q);
        alu_cmp_result_i = eq_now ^ alu_cmp_flip_o;
        alu_cmp_result_valid_i = alu_first_cycle_o ? (alu_a_o != alu_b_o) : 1'b1;
      end
      ALU_LT, ALU_LTU: begin
        hi_lt  = (alu_op_o == ALU_LT) ? ($signed(alu_a_o) < $signed(alu_b_o)) : (alu_a_o < alu_b_o);
        lt_now = alu_first_cycle_o ? (alu_a_o < alu_b_o)
                                   : (hi_lt || ((alu_a_o == alu_b_o) && lt_q));
        alu_cmp_result_i = lt_now ^ alu_cmp_flip_o;
        alu_cmp_result_valid_i = ~alu_first_cycle_o;
      end
      ALU_SLL: begin
        sh = {16'h0, alu_a_o} << alu_b_o[4:0];
        alu_result_i = sh[15:0] | (alu_first_cycle_o ? 16'h0 : spill_q);
        spill_d = sh[31:16];
      end
      ALU_SRL, ALU_SRA: begin
        if (alu_op_o == ALU_SRA && alu_first_cycle_o) sh = $signed({alu_a_o, 16'h0}) >>> alu_b_o[4:0];
        else sh = {alu_a_o, 16'h0} >> alu_b_o[4:0];
        alu_result_i = sh[31:16] | (alu_first_cycle_o ? 16'h0 : spill_q);
        spill_d = sh[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    carry_q <= sum[16];
    eq_q    <= eq_now;
    lt_q    <= lt_now;
    spill_q <= spill_d;
  end

  // ---------------- reference model (whole 32-bit op) ----------------
  function automatic logic [31:0] ref_result(input cs_alu_op op, input logic flip,
                                             input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_PLUS_4: return a + 32'd4;
      ALU_AND:    return a & b;
      ALU_OR:     return a | b;
      ALU_XOR:    return a ^ b;
      ALU_EQ:     return {31'b0, (a == b) ^ flip};
      ALU_LT:     return {31'b0, ($signed(a) < $signed(b)) ^ flip};
      ALU_LTU:    return {31'b0, (a < b) ^ flip};
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return $signed(a) >>> b[4:0];
      default:    return 32'h0;
    endcase
  endfunction

  // The ALU decides EQ in its first cycle whenever the low halves differ.
  function automatic int unsigned ref_latency(input cs_alu_op op, input logic [31:0] a,
                                              input logic [31:0] b);
`ifdef ALU_SEQ_EQ_EARLY_EXIT_EN
    if (op == ALU_EQ && a[15:0] != b[15:0]) return 2;
`endif
    return 3;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp = 0;
    end else begin
      if (req_ready_o)
        chk("alu_idle_zero", {alu_first_cycle_o, alu_op_o, alu_cmp_flip_o, alu_a_o, alu_b_o}, 64'd0);
      if (rsp_valid_o) begin
        if (exp_res_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
        end else begin
          if (!in_rsp) begin
            chk("latency", 64'(cyc - exp_acc_q[0]), 64'(exp_lat_q[0]));
            in_rsp = 1;
          end
          chk("rsp_result", 64'(rsp_result_o), 64'(exp_res_q[0]));
          chk("req_ready_in_resp", 64'(req_ready_o), 64'd0);
          chk("alu_resp_zero", {alu_first_cycle_o, alu_op_o, alu_cmp_flip_o, alu_a_o, alu_b_o}, 64'd0);
          if (rsp_ready_i) begin
            void'(exp_res_q.pop_front());
            void'(exp_lat_q.pop_front());
            void'(exp_acc_q.pop_front());
            in_rsp = 0;
            resp_seen++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic send(input cs_alu_op op, input logic flip, input logic [31:0] a,
                      input logic [31:0] b, output int unsigned acc);
    int n;
    n = 0;
    req_valid_i = 1'b1; req_op_i = op; req_cmp_flip_i = flip; req_a_i = a; req_b_i = b;
    while (!req_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    acc = cyc;
    if (!req_ready_o) begin
      chk("req_accept_timeout", 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b0;
      return;
    end
    exp_res_q.push_back(ref_result(op, flip, a, b));
    exp_lat_q.push_back(ref_latency(op, a, b));
    exp_acc_q.push_back(cyc);
    issued++;
    @(posedge clk); #1;
    // Scramble the request bus so a missing capture shows up as a wrong result.
    req_valid_i = 1'b0;
    req_op_i = cs_alu_op'($urandom_range(0, 11));
    req_cmp_flip_i = 1'($urandom_range(0, 1));
    req_a_i = $urandom;
    req_b_i = $urandom;
  endtask

  task automatic recv(input int hold);
    int n;
    n = 0;
    while (!rsp_valid_o && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid_o) begin
      chk("rsp_timeout", 64'(rsp_valid_o), 64'd1);
      return;
    end
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc, t0;
    cs_alu_op    r_op;
    logic [31:0] r_a, r_b;
    logic        r_flip;
    int          r_mode;
    req_valid_i = 0; req_op_i = ALU_ADD; req_cmp_flip_i = 0; req_a_i = 0; req_b_i = 0;
    rsp_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready_o), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result_o), 64'd0);
    chk("reset_alu_outputs", {alu_first_cycle_o, alu_op_o, alu_cmp_flip_o, alu_a_o, alu_b_o}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with carry across halves
    send(ALU_ADD, 1'b0, 32'h0000_FFFF, 32'h0000_0001, acc);
    chk("add_c1_a", 64'(alu_a_o), 64'h FFFF);
    chk("add_c1_b", 64'(alu_b_o), 64'h0001);
    chk("add_c1_fc", 64'(alu_first_cycle_o), 64'd1);
    chk("add_c1_op", 64'(alu_op_o), 64'(ALU_ADD));
    @(posedge clk); #1;
    chk("add_c2_a", 64'(alu_a_o), 64'h0000);
    chk("add_c2_fc", 64'(alu_first_cycle_o), 64'd0);
    recv(0);

    // SRL small amount, high half first
    send(ALU_SRL, 1'b0, 32'h8000_0000, 32'd4, acc);
    chk("srl_c1_a", 64'(alu_a_o), 64'h8000);
    chk("srl_c1_b", 64'(alu_b_o), 64'h0004);
    @(posedge clk); #1;
    chk("srl_c2_a", 64'(alu_a_o), 64'h0000);
    recv(0);

    // SRA by 20: fill cycle then restarted shift by 4
    send(ALU_SRA, 1'b1, 32'h8000_0000, 32'd20, acc);
    chk("sra_c1_a", 64'(alu_a_o), 64'h8000);
    chk("sra_c1_b", 64'(alu_b_o), 64'h0014);
    chk("sra_c1_flip", 64'(alu_cmp_flip_o), 64'd1);
    @(posedge clk); #1;
    chk("sra_c2_fc", 64'(alu_first_cycle_o), 64'd1);
    chk("sra_c2_b", 64'(alu_b_o), 64'h0004);
    chk("sra_c2_a", 64'(alu_a_o), 64'h8000);
    recv(0);

    // SLL by 20: low half crosses into the high half
    send(ALU_SLL, 1'b0, 32'h0000_0ABC, 32'd20, acc);
    @(posedge clk); #1;
    chk("sll_c2_a", 64'(alu_a_o), 64'h0ABC);
    recv(0);

    // EQ: low halves differ (early exit when enabled), then equal operands with flip
    send(ALU_EQ, 1'b0, 32'h0000_0001, 32'h0000_0000, acc);
    recv(0);
    send(ALU_EQ, 1'b1, 32'h1234_5678, 32'h1234_5678, acc);
    recv(0);
    send(ALU_LT, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, acc);
    recv(0);

    // Backpressure: hold the response 5 cycles, then a back-to-back request
    send(ALU_XOR, 1'b0, 32'h1234_0000, 32'h0000_5678, acc);
    recv(5);
    chk("ready_after_rsp", 64'(req_ready_o), 64'd1);
    t0 = cyc;
    send(ALU_SUB, 1'b0, 32'h0001_0000, 32'h0000_0001, acc);
    chk("accept_next_cycle", 64'(acc), 64'(t0));
    recv(0);

    // Reset in C2: transaction discarded, no response
    send(ALU_ADD, 1'b0, 32'h1111_1111, 32'h2222_2222, acc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req_ready", 64'(req_ready_o), 64'd1);
    chk("rst_mid_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_mid_rsp_result", 64'(rsp_result_o), 64'd0);
    void'(exp_res_q.pop_back());
    void'(exp_lat_q.pop_back());
    void'(exp_acc_q.pop_back());
    issued--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_response", 64'(rsp_valid_o), 64'd0);
    chk("rst_idle_ready", 64'(req_ready_o), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      r_op   = cs_alu_op'($urandom_range(0, 11));
      r_flip = 1'($urandom_range(0, 1));
      r_a    = $urandom;
      r_mode = int'($urandom_range(0, 3));
      if (r_mode == 0)      r_b = r_a;
      else if (r_mode == 1) r_b = {~r_a[31:16], r_a[15:0]};
      else                  r_b = $urandom;
      send(r_op, r_flip, r_a, r_b, acc);
      recv(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_res_q.size()), 64'd0);
    chk("response_count", 64'(resp_seen), 64'(issued));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
